merge16_sequencer: RTL and testbench
====================================

// Module: merge16_sequencer
// PURPOSE
//  Frame controller for the 16-to-8 cluster merge sorter. The sorter runs at clock4x with a fixed
//  pipeline latency and produces lowest-address-first results. This block sequences that sorter:
//  - tracks the 4-phase BX frame;
//  - launches a frame token on each bx_strobe and carries it alongside the sorter pipeline;
//  - captures the 8 sorted clusters when the token emerges;
//  - reports cluster count, overflow and BX-sync health.
// PARAMETERS
//  MXADRBITS    11   cluster address width; all-ones = invalid sentinel
//  MXCNTBITS    3    cluster size/count width
//  SORT_LAT     4    clock4x cycles from sorter input sample to valid sorter output (>=1)
//  LOCK_FRAMES  8    consecutive correctly spaced strobes required to assert locked (1..15)
// PORTS
//  clock4x       in   1              4x bunch-crossing clock
//  reset         in   1              asynchronous, active-high
//  bx_strobe     in   1              1-cycle pulse, first clock4x cycle of a BX frame
//  vpfs_in       in   16             valid flags presented to sorter in the bx_strobe cycle
//  sorted_adr    in   8*MXADRBITS    sorter outputs adr0..adr7, slot i at [i*MXADRBITS +: MXADRBITS]
//  sorted_cnt    in   8*MXCNTBITS    sorter outputs cnt0..cnt7, same packing
//  phase         out  2              current position in BX frame, 0 in strobe cycle
//  frame_valid   out  1              1-cycle pulse, cluster_* / n_clusters / overflow updated
//  cluster_adr   out  8*MXADRBITS    captured sorted addresses
//  cluster_cnt   out  8*MXCNTBITS    captured sorted counts
//  cluster_vld   out  8              per-slot valid, bit i = (cluster_adr slot i != all-ones)
//  n_clusters    out  5              popcount(vpfs_in) of captured frame, 0..16
//  overflow      out  1              n_clusters > 8 (clusters dropped by sorter)
//  locked        out  1              BX frame alignment established
//  sync_err      out  1              1-cycle pulse on misaligned or missing strobe
//  sync_err_cnt  out  8              saturating count of sync_err pulses
// BEHAVIOUR
//  Reset (async, any time):
//   - phase=0, locked=0, sync_err=0, sync_err_cnt=0, frame_valid=0.
//   - cluster_adr all-ones per slot, cluster_cnt=0, cluster_vld=0, n_clusters=0, overflow=0.
//   - All in-flight tokens flushed: no frame_valid for frames launched before reset.
//  Phase counter:
//   - bx_strobe forces phase to 0 in the strobe cycle; otherwise phase increments mod 4.
//   - Before the first strobe after reset, phase free-runs from 0.
//  Strobe checking (only after the first strobe following reset):
//   - Strobe is good iff it arrives when the free-running phase would be 0,
//     i.e. exactly 4 cycles after the previous strobe.
//   - Early strobe (phase would be 1..3): sync_err pulse, locked<=0, good-run counter<=0;
//     phase still realigns to 0.
//   - Missing strobe (phase wraps 3->0 with no strobe): sync_err pulse, locked<=0,
//     good-run counter<=0.
//   - Good strobe: good-run counter +1, saturating. locked<=1 when the counter reaches LOCK_FRAMES.
//   - sync_err_cnt increments on each sync_err pulse and saturates at 255.
//  Frame pipeline:
//   - Each bx_strobe launches a token with popcount(vpfs_in) into a SORT_LAT-deep shift register.
//     Back-to-back strobes each launch a token (full throughput); no token is ever dropped.
//   - Token launched at cycle T emerges at T+SORT_LAT. In that same cycle, the output registers
//     capture sorted_adr/sorted_cnt and the count.
//   - frame_valid, cluster_*, n_clusters and overflow change at the T+SORT_LAT clock edge,
//     i.e. are visible from cycle T+SORT_LAT+1. frame_valid is high for exactly one cycle.
//   - Outputs hold their last captured values until the next capture.
//   - Sync errors do not cancel tokens: a frame is always reported, and sync_err is flagged separately.
//  Arithmetic:
//   - n_clusters is a 5-bit popcount with no wrap (max 16).
//   - overflow = (n_clusters >= 9).
//   - cluster_vld is derived from the captured addresses, not from vpfs.
// TESTING
//  1. Reset, then bx_strobe every 4 cycles x10 -> locked rises on the 8th strobe; sync_err never pulses.
//  2. Strobe at T with vpfs_in=16'h0005 and the sorter returning adr0=3, adr1=9, rest 7FF ->
//     one frame_valid pulse visible at cycle T+5: cluster_vld=8'h03, n_clusters=2, overflow=0.
//  3. vpfs_in=16'hFFFF -> n_clusters=16, overflow=1, cluster_vld=8'hFF.
//  4. While locked, a strobe arrives 2 cycles early -> sync_err pulse, locked=0, sync_err_cnt=1,
//     phase=0 in that cycle. Then 8 good strobes -> locked=1.
//  5. One expected strobe omitted -> sync_err at the 3->0 wrap, locked=0.
//     Then 300 missing strobes -> sync_err_cnt saturates at 255.
//  6. Assert reset 2 cycles after a strobe -> all outputs at reset values; no frame_valid follows.

Source files
------------

// File: rtl/merge16_sequencer.sv
// BX frame controller for the 16-to-8 cluster merge sorter: phase tracking,
// strobe alignment health, and a token pipeline that captures sorter results.
module merge16_sequencer #(
  parameter int MXADRBITS   = 11,
  parameter int MXCNTBITS   = 3,
  parameter int SORT_LAT    = 4,
  parameter int LOCK_FRAMES = 8
) (
  input  logic                   clock4x,
  input  logic                   reset,
  input  logic                   bx_strobe,
  input  logic [15:0]            vpfs_in,
  input  logic [8*MXADRBITS-1:0] sorted_adr,
  input  logic [8*MXCNTBITS-1:0] sorted_cnt,
  output logic [1:0]             phase,
  output logic                   frame_valid,
  output logic [8*MXADRBITS-1:0] cluster_adr,
  output logic [8*MXCNTBITS-1:0] cluster_cnt,
  output logic [7:0]             cluster_vld,
  output logic [4:0]             n_clusters,
  output logic                   overflow,
  output logic                   locked,
  output logic                   sync_err,
  output logic [7:0]             sync_err_cnt
);

  localparam int LAST = SORT_LAT - 1;
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [MXADRBITS-1:0] ADR_INVALID = '1;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  // phase_q is where the free-running frame counter would be this cycle.
  logic [1:0] phase_q;
  logic       armed;
  logic [3:0] good_cnt;
  logic [3:0] good_next;
  logic       strobe_good;
  logic       strobe_early;
  logic       strobe_missing;
  logic       err_now;

  always_comb begin
    phase          = bx_strobe ? 2'd0 : phase_q;
    strobe_good    = bx_strobe && armed && (phase_q == 2'd0);
    strobe_early   = bx_strobe && armed && (phase_q != 2'd0);
    strobe_missing = !bx_strobe && armed && (phase_q == 2'd0);
    err_now        = strobe_early || strobe_missing;
    good_next      = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      phase_q      <= 2'd0;
      armed        <= 1'b0;
      good_cnt     <= 4'd0;
      locked       <= 1'b0;
      sync_err     <= 1'b0;
      sync_err_cnt <= 8'd0;
    end else begin
      phase_q  <= phase + 2'd1;
      sync_err <= err_now;
      if (err_now) begin
        locked   <= 1'b0;
        good_cnt <= 4'd0;
        if (sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
      end else if (bx_strobe && !armed) begin
        // The first strobe after reset starts the good run.
        armed    <= 1'b1;
        good_cnt <= 4'd1;
        if (LOCK_N <= 4'd1) locked <= 1'b1;
      end else if (strobe_good) begin
        good_cnt <= good_next;
        if (good_next >= LOCK_N) locked <= 1'b1;
      end
    end
  end

  // Token pipeline: bit LAST is visible in cycle T+SORT_LAT for a strobe at T.
  logic [SORT_LAT-1:0] tok_v;
  logic [4:0]          tok_n [SORT_LAT];

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      tok_v <= '0;
      for (int i = 0; i < SORT_LAT; i++) tok_n[i] <= 5'd0;
    end else begin
      tok_v[0] <= bx_strobe;
      tok_n[0] <= popcount16(vpfs_in);
      for (int i = 1; i < SORT_LAT; i++) begin
        tok_v[i] <= tok_v[i-1];
        tok_n[i] <= tok_n[i-1];
      end
    end
  end

  logic [7:0] slot_vld;

  always_comb begin
    slot_vld = '0;
    for (int i = 0; i < 8; i++)
      slot_vld[i] = (sorted_adr[i*MXADRBITS +: MXADRBITS] != ADR_INVALID);
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      cluster_adr <= '1;
      cluster_cnt <= '0;
      cluster_vld <= '0;
      n_clusters  <= 5'd0;
      overflow    <= 1'b0;
    end else begin
      frame_valid <= tok_v[LAST];
      if (tok_v[LAST]) begin
        cluster_adr <= sorted_adr;
        cluster_cnt <= sorted_cnt;
        cluster_vld <= slot_vld;
        n_clusters  <= tok_n[LAST];
        overflow    <= (tok_n[LAST] >= 5'd9);
      end
    end
  end

endmodule

// File: tb/tb_merge16_sequencer.sv
// Directed bench for merge16_sequencer: lock acquisition, frame capture,
// overflow, early/missing strobes, counter saturation and reset flush.
module tb_merge16_sequencer;

  logic         clock4x = 1'b0;
  logic         reset = 1'b1;
  logic         bx_strobe = 1'b0;
  logic [15:0]  vpfs_in = '0;
  logic [87:0]  sorted_adr = '1;
  logic [23:0]  sorted_cnt = '0;
  logic [1:0]   phase;
  logic         frame_valid;
  logic [87:0]  cluster_adr;
  logic [23:0]  cluster_cnt;
  logic [7:0]   cluster_vld;
  logic [4:0]   n_clusters;
  logic         overflow;
  logic         locked;
  logic         sync_err;
  logic [7:0]   sync_err_cnt;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int se_seen = 0;
  int fv_base;

  merge16_sequencer dut (
    .clock4x(clock4x), .reset(reset), .bx_strobe(bx_strobe), .vpfs_in(vpfs_in),
    .sorted_adr(sorted_adr), .sorted_cnt(sorted_cnt), .phase(phase),
    .frame_valid(frame_valid), .cluster_adr(cluster_adr), .cluster_cnt(cluster_cnt),
    .cluster_vld(cluster_vld), .n_clusters(n_clusters), .overflow(overflow),
    .locked(locked), .sync_err(sync_err), .sync_err_cnt(sync_err_cnt)
  );

  always #5 clock4x = ~clock4x;

  always @(negedge clock4x) begin
    if (frame_valid === 1'b1) fv_seen++;
    if (sync_err === 1'b1) se_seen++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock4x cycle; returns 1 time unit after the edge that ends it.
  task automatic cyc(input logic s, input logic [15:0] v);
    bx_strobe = s;
    vpfs_in   = v;
    @(posedge clock4x);
    #1;
    bx_strobe = 1'b0;
    vpfs_in   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_phase"}, 128'(phase), 128'(0));
    check({pfx, "_locked"}, 128'(locked), 128'(0));
    check({pfx, "_sync_err"}, 128'(sync_err), 128'(0));
    check({pfx, "_sync_err_cnt"}, 128'(sync_err_cnt), 128'(0));
    check({pfx, "_frame_valid"}, 128'(frame_valid), 128'(0));
    check({pfx, "_cluster_adr"}, 128'(cluster_adr), {40'h0, 88'hFF_FFFF_FFFF_FFFF_FFFF_FFFF});
    check({pfx, "_cluster_cnt"}, 128'(cluster_cnt), 128'(0));
    check({pfx, "_cluster_vld"}, 128'(cluster_vld), 128'(0));
    check({pfx, "_n_clusters"}, 128'(n_clusters), 128'(0));
    check({pfx, "_overflow"}, 128'(overflow), 128'(0));
  endtask

  initial begin
    // Reset and free-running phase
    repeat (2) @(posedge clock4x);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    cyc(1'b0, 16'h0);
    check("phase_freerun", 128'(phase), 128'(1));

    // Test 1: ten aligned strobes, lock on the 8th
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'h0);
      if (i == 6) check("lock_before_8th", 128'(locked), 128'(0));
      if (i == 7) check("lock_at_8th", 128'(locked), 128'(1));
      idle(3);
    end
    check("t1_no_sync_err", 128'(se_seen), 128'(0));
    check("t1_sync_err_cnt", 128'(sync_err_cnt), 128'(0));

    // Test 2: vpfs=0005, sorter returns adr0=3, adr1=9 (strobe at T)
    sorted_adr = {{6{11'h7FF}}, 11'd9, 11'd3};
    sorted_cnt = {18'd0, 3'd1, 3'd2};
    cyc(1'b1, 16'h0005);
    idle(3);
    check("t2_no_fv_at_T4", 128'(frame_valid), 128'(0));
    fv_base = fv_seen;
    cyc(1'b1, 16'hFFFF);  // Test 3 strobe at T+4; sorter still shows frame T this cycle
    check("t2_fv_at_T5", 128'(frame_valid), 128'(1));
    check("t2_cluster_vld", 128'(cluster_vld), 128'(8'h03));
    check("t2_n_clusters", 128'(n_clusters), 128'(2));
    check("t2_overflow", 128'(overflow), 128'(0));
    check("t2_cluster_adr", 128'(cluster_adr), 128'({{6{11'h7FF}}, 11'd9, 11'd3}));
    check("t2_cluster_cnt", 128'(cluster_cnt), 128'(24'h00000A));
    sorted_adr = {11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0};
    sorted_cnt = {8{3'd7}};
    idle(1);
    check("t2_fv_one_cycle", 128'(frame_valid), 128'(0));
    check("t2_fv_single_pulse", 128'(fv_seen - fv_base), 128'(1));
    idle(2);

    // Test 3: all 16 flags set (strobe at T+8 captures frame T+4)
    cyc(1'b1, 16'h0);
    check("t3_fv", 128'(frame_valid), 128'(1));
    check("t3_n_clusters", 128'(n_clusters), 128'(16));
    check("t3_overflow", 128'(overflow), 128'(1));
    check("t3_cluster_vld", 128'(cluster_vld), 128'(8'hFF));
    check("t3_cluster_adr", 128'(cluster_adr),
          128'({11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0}));
    idle(3);

    // Test 4: strobe two cycles early while locked
    check("t4_locked_before", 128'(locked), 128'(1));
    cyc(1'b1, 16'h0);
    idle(1);
    bx_strobe = 1'b1;
    #1;
    check("t4_phase_early", 128'(phase), 128'(0));
    @(posedge clock4x);
    #1;
    bx_strobe = 1'b0;
    check("t4_sync_err", 128'(sync_err), 128'(1));
    check("t4_unlocked", 128'(locked), 128'(0));
    check("t4_sync_err_cnt", 128'(sync_err_cnt), 128'(1));
    idle(1);
    check("t4_sync_err_pulse", 128'(sync_err), 128'(0));
    idle(2);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'h0);
      if (i == 6) check("t4_relock_7", 128'(locked), 128'(0));
      if (i == 7) check("t4_relock_8", 128'(locked), 128'(1));
      idle(3);
    end
    check("t4_sync_err_cnt_hold", 128'(sync_err_cnt), 128'(1));

    // Test 5: missing strobe, then saturation
    idle(1);
    check("t5_sync_err_missing", 128'(sync_err), 128'(1));
    check("t5_unlocked", 128'(locked), 128'(0));
    check("t5_sync_err_cnt", 128'(sync_err_cnt), 128'(2));
    idle(1200);
    check("t5_saturate", 128'(sync_err_cnt), 128'(255));

    // Test 6: reset two cycles after a strobe flushes the token
    cyc(1'b1, 16'h00FF);
    idle(1);
    fv_base = fv_seen;
    reset = 1'b1;
    #1;
    check_reset_values("t6");
    repeat (2) @(posedge clock4x);
    #1;
    reset = 1'b0;
    idle(8);
    check("t6_no_fv_after_reset", 128'(fv_seen - fv_base), 128'(0));
    check("t6_n_clusters_held", 128'(n_clusters), 128'(0));
    check("t6_cluster_vld_held", 128'(cluster_vld), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
